// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the pipelined MIPS core.
// Arbitrates fetch advance against cache stalls, load-use bubbles, control
// redirects and halt. A redirect that cannot be taken immediately is held in
// pend_q and replayed once fetch can advance.
// Optional build macro: PC_SEQ_PERF_EN adds stall_cycles / redirect_count.
//
//   state  | meaning
//   RUN    | normal fetch; redirects taken with zero latency
//   WAIT_D | data access outstanding; PC and IF/ID held until dhit
//   WAIT_I | redirect pending in pend_q; replayed on the next advance
//   HALTED | core stopped; only reset exits
module pc_sequencer #(
  parameter int WAIT_LIMIT = 64,
  parameter int PERF_W     = 32
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       dmem_req,
  input  logic       load_use,
  input  logic       br_taken,
  input  logic       jmp,
  input  logic       jr,
  input  logic       halt,
  output logic       pc_en,
  output logic [2:0] PCSrc,
  output logic       stall_ifid,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic       halted,
  output logic       timeout
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] redirect_count
`endif
);

  typedef enum logic [1:0] {RUN, WAIT_D, WAIT_I, HALTED} state_e;

  localparam int WDOG_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WAIT_LIMIT);

  state_e            state_q, state_d;
  logic [2:0]        pend_q, pend_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;

  logic       mem_stall, adv, redir, in_wait, run_like;
  logic [2:0] src;

  assign mem_stall = dmem_req & ~dhit;
  assign adv       = ihit & ~mem_stall;
  assign redir     = br_taken | jr | jmp;
  // Branch wins over JR, JR over J; losers in the same cycle are dropped.
  assign src       = br_taken ? 3'd1 : (jr ? 3'd3 : 3'd2);
  assign in_wait   = (state_q == WAIT_D) || (state_q == WAIT_I);
  // The dhit cycle of WAIT_D is handled exactly like a RUN cycle.
  assign run_like  = (state_q == RUN) || ((state_q == WAIT_D) && dhit);

  // State, pending redirect and watchdog registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= RUN;
      pend_q    <= 3'd0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  // Watchdog: saturating count of consecutive wait-state cycles; sticky flag.
  always_comb begin
    wdog_d    = '0;
    timeout_d = timeout_q;
    if (in_wait) begin
      wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + WDOG_W'(1);
      if ((WAIT_LIMIT != 0) && (wdog_d == WDOG_MAX)) timeout_d = 1'b1;
    end
  end

  // Next-state and output decode; outputs are held low during reset.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pc_en      = 1'b0;
    PCSrc      = 3'd0;
    stall_ifid = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    halted     = (state_q == HALTED);
    timeout    = timeout_q;
    if (run_like) begin
      if (mem_stall) begin
        stall_ifid = 1'b1;
        if (redir) begin
          pend_d  = src;
          state_d = WAIT_I;
        end else begin
          state_d = WAIT_D;
        end
      end else if (redir) begin
        if (ihit) begin
          pc_en      = 1'b1;
          PCSrc      = src;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          state_d    = RUN;
        end else begin
          pend_d  = src;
          state_d = WAIT_I;
        end
      end else if (load_use) begin
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
        state_d    = RUN;
      end else if (halt) begin
        flush_ifid = 1'b1;
        state_d    = HALTED;
      end else begin
        pc_en   = ihit;
        state_d = RUN;
      end
    end else begin
      unique case (state_q)
        WAIT_D: stall_ifid = 1'b1;
        WAIT_I: begin
          if (adv) begin
            pc_en      = 1'b1;
            PCSrc      = pend_q;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            state_d    = RUN;
          end else begin
            stall_ifid = 1'b1;
          end
        end
        HALTED: stall_ifid = 1'b1;
        default: state_d = RUN;
      endcase
    end
    if (!nRST) begin
      pc_en      = 1'b0;
      PCSrc      = 3'd0;
      stall_ifid = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      halted     = 1'b0;
      timeout    = 1'b0;
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, redir_cnt_q;

  // Saturating performance counters for stalls and taken redirects.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (!pc_en && (state_q != HALTED) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (pc_en && (PCSrc != 3'd0) && (redir_cnt_q != '1))
        redir_cnt_q <= redir_cnt_q + PERF_W'(1);
    end
  end

  assign stall_cycles   = stall_cnt_q;
  assign redirect_count = redir_cnt_q;
`else
  logic [PERF_W-1:0] perf_unused;
  assign perf_unused = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (WAIT_LIMIT = 4).
module tb_pc_sequencer;
  logic       CLK, nRST;
  logic       ihit, dhit, dmem_req, load_use, br_taken, jmp, jr, halt;
  logic       pc_en;
  logic [2:0] PCSrc;
  logic       stall_ifid, flush_ifid, flush_idex, halted, timeout;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] stall_cycles, redirect_count;
`endif

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.WAIT_LIMIT(4), .PERF_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .load_use(load_use), .br_taken(br_taken), .jmp(jmp), .jr(jr), .halt(halt),
    .pc_en(pc_en), .PCSrc(PCSrc), .stall_ifid(stall_ifid),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .halted(halted),
    .timeout(timeout)
`ifdef PC_SEQ_PERF_EN
    , .stall_cycles(stall_cycles), .redirect_count(redirect_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic drive(input logic ih, dh, dr, lu, br, jp, jrr, hl);
    ihit = ih; dhit = dh; dmem_req = dr; load_use = lu;
    br_taken = br; jmp = jp; jr = jrr; halt = hl;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic pe, input logic [2:0] src,
                            input logic sf, input logic fi, input logic fd);
    chk({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, pe});
    chk({tag, ".PCSrc"}, {29'd0, PCSrc}, {29'd0, src});
    chk({tag, ".stall_ifid"}, {31'd0, stall_ifid}, {31'd0, sf});
    chk({tag, ".flush_ifid"}, {31'd0, flush_ifid}, {31'd0, fi});
    chk({tag, ".flush_idex"}, {31'd0, flush_idex}, {31'd0, fd});
  endtask

  task automatic sample;
    @(negedge CLK);
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    sample;
    check_outs("reset", 0, 0, 0, 0, 0);
    chk("reset.halted", {31'd0, halted}, 32'd0);
    chk("reset.timeout", {31'd0, timeout}, 32'd0);
    step;
    nRST = 1'b1;

    // plain fetch
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      sample; check_outs("fetch", 1, 0, 0, 0, 0); step;
    end

    // zero-latency branch
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    sample; check_outs("br", 1, 1, 0, 1, 1); step;

    // jr without ihit, held in WAIT_I then replayed
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    sample;
    chk("jr_c1.pc_en", {31'd0, pc_en}, 32'd0);
    chk("jr_c1.flush_ifid", {31'd0, flush_ifid}, 32'd0);
    step;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample; check_outs("jr_c2", 0, 0, 1, 0, 0); step;
    sample; check_outs("jr_c3", 0, 0, 1, 0, 0); step;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    sample; check_outs("jr_c4", 1, 3, 0, 1, 1); step;
    sample; check_outs("jr_run", 1, 0, 0, 0, 0); step;

    // priority
    drive(1, 0, 0, 0, 1, 1, 0, 0);
    sample; check_outs("br_jmp", 1, 1, 0, 1, 1); step;
    drive(1, 0, 0, 0, 0, 1, 1, 0);
    sample; check_outs("jr_jmp", 1, 3, 0, 1, 1); step;
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    sample; check_outs("jmp", 1, 2, 0, 1, 1); step;

    // load-use bubble
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    sample; check_outs("lu", 0, 0, 1, 0, 1); step;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    sample; check_outs("lu_after", 1, 0, 0, 0, 0); step;

    // data stall with watchdog at 4
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      sample;
      check_outs("dstall", 0, 0, 1, 0, 0);
      chk("dstall.timeout", {31'd0, timeout}, 32'd0);
      step;
    end
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    sample;
    check_outs("dhit", 1, 0, 0, 0, 0);
    chk("dhit.timeout", {31'd0, timeout}, 32'd1);
    step;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    sample;
    check_outs("after_d", 1, 0, 0, 0, 0);
    chk("sticky.timeout", {31'd0, timeout}, 32'd1);
    step;

    // redirect during a data stall goes to WAIT_I; later redirects ignored
    drive(1, 0, 1, 0, 1, 0, 0, 0);
    sample; check_outs("br_mstall", 0, 0, 1, 0, 0); step;
    drive(1, 1, 1, 0, 0, 1, 0, 0);
    sample; check_outs("br_replay", 1, 1, 0, 1, 1); step;

    // halt while a redirect is pending: redirect first, halt next cycle
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    sample; chk("jmp_hold.pc_en", {31'd0, pc_en}, 32'd0); step;
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    sample;
    check_outs("halt_pend", 1, 2, 0, 1, 1);
    chk("halt_pend.halted", {31'd0, halted}, 32'd0);
    step;
    sample;
    check_outs("halt_run", 0, 0, 0, 1, 0);
    chk("halt_run.halted", {31'd0, halted}, 32'd0);
    step;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    sample;
    check_outs("halted1", 0, 0, 1, 0, 0);
    chk("halted1.halted", {31'd0, halted}, 32'd1);
    step;
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    sample;
    check_outs("halted2", 0, 0, 1, 0, 0);
    chk("halted2.halted", {31'd0, halted}, 32'd1);
    step;

    // reset pulse mid-halt
    nRST = 1'b0;
    #1;
    check_outs("rst_halt", 0, 0, 0, 0, 0);
    chk("rst_halt.halted", {31'd0, halted}, 32'd0);
    chk("rst_halt.timeout", {31'd0, timeout}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    step;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    sample;
    check_outs("post_rst", 1, 0, 0, 0, 0);
    chk("post_rst.halted", {31'd0, halted}, 32'd0);
    step;

    // reset mid-WAIT_I discards the pending redirect
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample; check_outs("waiti", 0, 0, 1, 0, 0);
    @(posedge CLK); #1;
    nRST = 1'b0;
    #1;
    chk("rst_waiti.stall_ifid", {31'd0, stall_ifid}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    step;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    sample; check_outs("rst_waiti_run", 1, 0, 0, 0, 0);
    step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
